scan_sequencer: RTL
===================

Name: scan_sequencer

Overview:
- Upstream driver for the 2-to-4 enable decoder.
- Time-multiplexes 4 display/output slots. Produces the 2-bit select code `sel` and the enable `en` that feed the decoder's A and EN inputs.
- Inserts a blanking dead-time (`en` low) between slots to prevent ghosting, skips masked slots, and reports frame completion.

Parameters:
- PRESCALE, 1000: cycles `en` is held high per active slot; must be ≥ 1.
- BLANK_CYCLES, 4: cycles `en` is held low before each slot; must be ≥ 1.
- CNT_W, 16: width of the internal slot counter; must satisfy 2^CNT_W > max(PRESCALE, BLANK_CYCLES).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE to begin scanning.
- stop  input  1  level; requests a return to IDLE at the end of the current slot.
- digit_mask  input  4  bit i=1 enables slot i; sampled only at slot boundaries.
- sel  output  2  slot index to the decoder's A.
- en  output  1  decoder enable.
- busy  output  1  high in any state other than IDLE.
- frame_done  output  1  one-cycle pulse marking the end of a frame.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, sel=2'b00, en=0, busy=0, frame_done=0, counter=0.
  - Reset mid-slot aborts immediately; no frame_done is emitted.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, BLANK, ON.
- IDLE:
  - en=0; sel holds its last value.
  - If start=1 and digit_mask≠0 at a clock edge, go to BLANK next cycle. sel = lowest set bit of digit_mask; counter=0.
  - start with digit_mask=0 is ignored.
- BLANK:
  - en=0 for exactly BLANK_CYCLES cycles, then ON.
- ON:
  - en=1 for exactly PRESCALE cycles.
  - On the last ON cycle (slot boundary), evaluate stop, digit_mask and the next slot.
- Slot boundary, in priority order:
  1. stop=1 or digit_mask=0 → IDLE. frame_done pulses if the completed slot was the last of its frame.
  2. Otherwise next sel = first set bit of digit_mask searching circularly from sel+1 (3 wraps to 0). Go to BLANK.
- Wrap rule:
  - A frame ends when next sel ≤ current sel, including next = current when only one slot is enabled.
  - frame_done=1 in the first cycle after the boundary, i.e. the first BLANK (or IDLE) cycle. It is high for exactly 1 cycle.
- Slot period = BLANK_CYCLES + PRESCALE cycles.
- Frame period = popcount(digit_mask) × slot period.
- stop during IDLE or BLANK:
  - No immediate effect; only the level at the ON-to-next boundary counts.
  - stop must be high at that boundary cycle; the block does not latch it.
- start and stop both high in IDLE: start wins (scan begins). stop is evaluated at the first boundary.
- sel changes only while en=0, so the decoder never sees a select change while enabled.

Optional Feature:
- Macro: SCAN_BRIGHTNESS_EN.
- Defined:
  - Adds input `brightness [3:0]`, sampled at slot boundaries.
  - During ON, en=1 only while on_cnt < THR, where THR = ((brightness+1) × PRESCALE) >> 4; otherwise en=0.
  - ON duration, sel timing and frame_done timing are unchanged.
  - brightness=15 gives THR=PRESCALE, i.e. full on.
  - THR=0 (possible when PRESCALE<16) gives en=0 for the whole slot.
- Undefined: the port is absent and en=1 for the full ON phase.

Decomposition:
- Package scan_pkg:
  - state enum {IDLE, BLANK, ON}.
  - NUM_SLOTS=4, SEL_W=2.
  - Function popcount4.
- Sub-module scan_next_sel (combinational):
  - Inputs: cur_sel, digit_mask.
  - Outputs: next_sel, wrap, none (mask=0).
- Top level: FSM, counter, output registers.

Test Plan (PRESCALE=8, BLANK_CYCLES=2):
- Full mask: reset, digit_mask=4'hF, start pulse.
  - sel sequence 0,1,2,3,0…
  - Each slot: en low 2 cycles then high 8 cycles.
  - frame_done every 40 cycles, first one at the first cycle after slot 3's ON phase.
- Masked slots: digit_mask=4'b1010.
  - sel alternates 1,3; frame_done every 20 cycles.
  - Mask changed to 4'b0100 mid-slot: takes effect at the next boundary; sel=2 thereafter, frame_done every 10 cycles.
- Graceful stop: stop raised during slot 2's ON phase and held.
  - Slot 2 completes its full 8 en-high cycles, then IDLE, busy=0, en=0.
  - No frame_done, because slot 2 is not the last slot.
- Start ignored: digit_mask=0 with start=1 → stays IDLE, busy=0.
- Reset mid-operation: rst_n low during slot 1's ON phase → en=0, sel=0, busy=0 asynchronously, before the next clock edge.
- SCAN_BRIGHTNESS_EN:
  - brightness=7 → THR=4: en high 4 of the 8 ON cycles.
  - brightness=15: en high all 8 ON cycles.
  - Period unchanged at 10 cycles per slot.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: shared state type, slot constants and helpers for the scan sequencer.
package scan_pkg;
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  localparam int NUM_SLOTS = 4;
  localparam int SEL_W = 2;
  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction
endpackage

// File: rtl/scan_next_sel.sv
// scan_next_sel: circular search for the next enabled slot after cur_sel, with wrap and empty-mask flags.
module scan_next_sel
  import scan_pkg::*;
(
  input  logic [SEL_W-1:0]     cur_sel,
  input  logic [NUM_SLOTS-1:0] digit_mask,
  output logic [SEL_W-1:0]     next_sel,
  output logic                 wrap,
  output logic                 none
);
  // Descending scan so the nearest set bit after cur_sel wins; k=NUM_SLOTS lands on cur_sel itself.
  always_comb begin
    next_sel = cur_sel;
    for (int k = NUM_SLOTS; k >= 1; k--)
      if (digit_mask[cur_sel + SEL_W'(k)]) next_sel = cur_sel + SEL_W'(k);
  end
  assign none = ~|digit_mask;
  assign wrap = ~none & (next_sel <= cur_sel);
endmodule

// File: rtl/scan_sequencer.sv
// scan_sequencer: time-multiplexed 4-slot select/enable driver with blanking, slot masking and frame pulse.
// Optional SCAN_BRIGHTNESS_EN adds a 4-bit brightness input that trims the enabled portion of each ON phase.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_SLOTS-1:0] digit_mask,
`ifdef SCAN_BRIGHTNESS_EN
  input  logic [3:0]           brightness,
`endif
  output logic [SEL_W-1:0]     sel,
  output logic                 en,
  output logic                 busy,
  output logic                 frame_done
);
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLANK_CYCLES - 1);
  state_t           state;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] cur_sel, nsel;
  logic             wrap, none, en_first, en_next, go, boundary;
  // In IDLE, searching from the top slot yields the lowest set bit.
  assign cur_sel  = state == IDLE ? SEL_W'(NUM_SLOTS - 1) : sel;
  assign cnt_nx   = cnt + CNT_W'(1);
  assign go       = state == IDLE && start && !none;
  assign boundary = state == ON && cnt == P_LAST;
  scan_next_sel u_next (
    .cur_sel   (cur_sel),
    .digit_mask(digit_mask),
    .next_sel  (nsel),
    .wrap      (wrap),
    .none      (none)
  );
`ifdef SCAN_BRIGHTNESS_EN
  logic [CNT_W+3:0] prod;
  logic [CNT_W-1:0] thr;
  assign prod = ((CNT_W+4)'(brightness) + (CNT_W+4)'(1)) * (CNT_W+4)'(PRESCALE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) thr <= '0;
    else if (go || boundary) thr <= CNT_W'(prod >> 4);
  assign en_first = thr != '0;
  assign en_next  = cnt_nx < thr;
`else
  assign en_first = 1'b1;
  assign en_next  = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel        <= '0;
      en         <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (go) begin
          state <= BLANK;
          sel   <= nsel;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        BLANK: if (cnt == B_LAST) begin
          state <= ON;
          cnt   <= '0;
          en    <= en_first;
        end else cnt <= cnt_nx;
        ON: if (boundary) begin
          cnt        <= '0;
          en         <= 1'b0;
          frame_done <= wrap;
          if (stop || none) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= BLANK;
            sel   <= nsel;
          end
        end else begin
          cnt <= cnt_nx;
          en  <= en_next;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
